// File: rtl/complemento_serial.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : complemento_serial
// Description : Bit-serial ones'/two's complement unit. Latches a WIDTH-bit
//               operand on start, emits the result one bit per clock (LSB
//               first) into a result register, then pulses done for one cycle
//               together with zero and overflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
module complemento_serial #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] din,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic             zero,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_sreg;
    logic [WIDTH-1:0] r_res;
    logic [CW-1:0]    r_cnt;
    logic             r_mode;
    logic             r_seen_one;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_dout;
    logic             r_zero;
    logic             r_ovf;

    logic             w_bit;
    logic             w_res_bit;
    logic [WIDTH-1:0] w_res_next;
    logic             w_last;
    logic             w_ovf;

    // Serial complement datapath for the bit currently at the bottom of the
    // shift register. Two's complement copies bits up to and including the
    // first 1, then inverts the rest. Overflow is the case where the only 1
    // in the operand is its MSB, i.e. no 1 has been seen before the last bit.
    always_comb begin
        w_bit      = r_sreg[0];
        w_res_bit  = r_mode ? (r_seen_one ? ~w_bit : w_bit) : ~w_bit;
        w_res_next = {w_res_bit, r_res[WIDTH-1:1]};
        w_last     = (r_cnt == C_LAST);
        w_ovf      = r_mode & ~r_seen_one & w_bit;
    end

    // Control FSM, shift/count registers and registered result flags.
    // The edge that leaves DONE also samples start, so a held start gives
    // back-to-back operations every WIDTH+1 clocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_sreg     <= '0;
            r_res      <= '0;
            r_cnt      <= '0;
            r_mode     <= 1'b0;
            r_seen_one <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_dout     <= '0;
            r_zero     <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sreg     <= din;
                        r_mode     <= mode;
                        r_seen_one <= 1'b0;
                        r_cnt      <= '0;
                        r_res      <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_sreg     <= {1'b0, r_sreg[WIDTH-1:1]};
                    r_seen_one <= r_seen_one | w_bit;
                    r_res      <= w_res_next;
                    r_cnt      <= r_cnt + C_ONE;
                    if (w_last) begin
                        r_dout  <= w_res_next;
                        r_done  <= 1'b1;
                        r_zero  <= (w_res_next == '0);
                        r_ovf   <= w_ovf;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_sreg     <= din;
                        r_mode     <= mode;
                        r_seen_one <= 1'b0;
                        r_cnt      <= '0;
                        r_res      <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= S_SHIFT;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Output ports are direct copies of registers.
    always_comb begin
        busy = r_busy;
        done = r_done;
        dout = r_dout;
        zero = r_zero;
        ovf  = r_ovf;
    end

endmodule
`default_nettype wire

// File: tb/tb_complemento_serial.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_complemento_serial
// Description : Directed self-checking bench for complemento_serial with a
//               WIDTH=4 and a WIDTH=8 instance sharing clock and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_complemento_serial;

    logic       clk;
    logic       rst;

    logic       s4_start, s4_mode;
    logic [3:0] s4_din;
    logic       b4, d4, z4, o4;
    logic [3:0] q4;

    logic       s8_start, s8_mode;
    logic [7:0] s8_din;
    logic       b8, d8, z8, o8;
    logic [7:0] q8;

    int checks = 0;
    int errors = 0;

    complemento_serial #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(s4_start), .mode(s4_mode), .din(s4_din),
        .busy(b4), .done(d4), .dout(q4), .zero(z4), .ovf(o4)
    );

    complemento_serial #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(s8_start), .mode(s8_mode), .din(s8_din),
        .busy(b8), .done(d8), .dout(q8), .zero(z8), .ovf(o8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Arithmetic reference: ones' = bitwise NOT, two's = negation mod 2^w.
    function automatic logic [7:0] ref_res(input int w, input logic [7:0] d, input logic m);
        logic [7:0] mask;
        mask = (w == 4) ? 8'h0F : 8'hFF;
        return m ? ((8'h00 - (d & mask)) & mask) : (~d & mask);
    endfunction

    function automatic logic ref_ovf(input int w, input logic [7:0] d, input logic m);
        return m && (d == ((w == 4) ? 8'h08 : 8'h80));
    endfunction

    // Issues one start pulse and checks latency, busy, done width and results.
    // Entered and left one time unit after a rising edge.
    task automatic run_op(input int w, input logic [7:0] d, input logic m, input string tag);
        logic [7:0] er;
        logic       ez, eo;
        er = ref_res(w, d, m);
        ez = (er == 8'h00);
        eo = ref_ovf(w, d, m);
        if (w == 4) begin s4_start = 1'b1; s4_din = d[3:0]; s4_mode = m; end
        else        begin s8_start = 1'b1; s8_din = d;      s8_mode = m; end
        @(posedge clk); #1;
        s4_start = 1'b0; s8_start = 1'b0;
        chk({tag, " busy0"}, {7'd0, (w == 4) ? b4 : b8}, 8'd1);
        for (int i = 1; i <= w; i++) begin
            @(posedge clk); #1;
            chk({tag, " done"}, {7'd0, (w == 4) ? d4 : d8}, {7'd0, i == w});
            chk({tag, " busy"}, {7'd0, (w == 4) ? b4 : b8}, 8'd1);
        end
        chk({tag, " dout"}, (w == 4) ? {4'd0, q4} : q8, er);
        chk({tag, " zero"}, {7'd0, (w == 4) ? z4 : z8}, {7'd0, ez});
        chk({tag, " ovf"},  {7'd0, (w == 4) ? o4 : o8}, {7'd0, eo});
        @(posedge clk); #1;
        chk({tag, " done_drop"}, {7'd0, (w == 4) ? d4 : d8}, 8'd0);
        chk({tag, " idle"},      {7'd0, (w == 4) ? b4 : b8}, 8'd0);
        chk({tag, " dout_hold"}, (w == 4) ? {4'd0, q4} : q8, er);
    endtask

    initial begin
        rst = 1'b1;
        s4_start = 1'b0; s4_mode = 1'b0; s4_din = 4'd0;
        s8_start = 1'b0; s8_mode = 1'b0; s8_din = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst dout", {4'd0, q4}, 8'd0);
        chk("rst busy", {7'd0, b4}, 8'd0);
        chk("rst done", {7'd0, d4}, 8'd0);
        chk("rst zero", {7'd0, z4}, 8'd0);
        chk("rst ovf",  {7'd0, o4}, 8'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Ones' complement, two's complement corner cases
        run_op(4, 8'h05, 1'b0, "t1");
        chk("t1 value", {4'd0, q4}, 8'h0A);
        run_op(4, 8'h06, 1'b1, "t2a");
        chk("t2a value", {4'd0, q4}, 8'h0A);
        run_op(4, 8'h00, 1'b1, "t2b");
        chk("t2b zero", {7'd0, z4}, 8'd1);
        run_op(4, 8'h08, 1'b1, "t2c");
        chk("t2c ovf", {7'd0, o4}, 8'd1);

        // Every operand in both modes
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < 16; i++)
                run_op(4, 8'(i), m[0], "t3");

        // Held start: back-to-back every 5 clocks, din change mid-flight ignored
        s4_start = 1'b1; s4_din = 4'b0011; s4_mode = 1'b0;
        @(posedge clk); #1;
        for (int e = 1; e <= 9; e++) begin
            @(posedge clk); #1;
            chk("t4 done", {7'd0, d4}, {7'd0, (e == 4) || (e == 9)});
            chk("t4 busy", {7'd0, b4}, 8'd1);
            if (e == 2) s4_din = 4'b1111;
            if (e == 4) chk("t4 first", {4'd0, q4}, 8'h0C);
            if (e == 9) begin
                chk("t4 second", {4'd0, q4}, 8'h00);
                chk("t4 zero", {7'd0, z4}, 8'd1);
                s4_start = 1'b0;
            end
        end
        @(posedge clk); #1;
        chk("t4 idle", {7'd0, b4}, 8'd0);

        // Asynchronous reset mid-operation
        run_op(4, 8'h05, 1'b0, "t5pre");
        s4_start = 1'b1; s4_din = 4'b0001; s4_mode = 1'b1;
        @(posedge clk); #1;
        s4_start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("t5 dout", {4'd0, q4}, 8'd0);
        chk("t5 busy", {7'd0, b4}, 8'd0);
        chk("t5 done", {7'd0, d4}, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int e = 0; e < 6; e++) begin
            @(posedge clk); #1;
            chk("t5 no_done", {7'd0, d4}, 8'd0);
        end
        run_op(4, 8'h01, 1'b1, "t5post");
        chk("t5 value", {4'd0, q4}, 8'h0F);

        // Eight-bit instance
        run_op(8, 8'h80, 1'b1, "t6a");
        chk("t6a ovf", {7'd0, o8}, 8'd1);
        run_op(8, 8'h01, 1'b1, "t6b");
        chk("t6b value", q8, 8'hFF);
        run_op(8, 8'h5A, 1'b0, "t6c");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
